// File: rtl/sample_load_arbiter.sv
// sample_load_arbiter
// -------------------
// Round-robin arbiter and pacing controller for a shared sample register.
// One requester is granted per load; its data word is captured into q and
// the winner receives a one-cycle ack. After each load the register is
// frozen for HOLD cycles (busy high) so the downstream consumer sees a
// stable value.
//
// Ports:
//   clk        clock, all state changes on posedge
//   reset      synchronous, active-high reset
//   req        per-requester load request (level)
//   din        packed request data, requester i at [i*W +: W]
//   q          sample register
//   q_valid    high from the first load until reset
//   ack        one-hot pulse marking the requester loaded at the previous edge
//   busy       high during the hold window
//   last_grant index of the most recently granted requester
module sample_load_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 16,
    parameter int HOLD = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*W-1:0]       din,
    output logic [W-1:0]            q,
    output logic                    q_valid,
    output logic [NREQ-1:0]         ack,
    output logic                    busy,
    output logic [$clog2(NREQ)-1:0] last_grant
);

    localparam int LGW = $clog2(NREQ);
    localparam logic [7:0] HOLD_M1 = (HOLD > 0) ? 8'(HOLD - 1) : 8'd0;
    localparam logic [LGW-1:0] LG_RST = LGW'(NREQ - 1);

    typedef enum logic {IDLE, HOLDING} state_t;

    state_t          state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [W-1:0]    sample_q, sample_d;
    logic            valid_q, valid_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic            busy_q, busy_d;
    logic [LGW-1:0]  lg_q, lg_d;

    logic [W-1:0]    din_arr [NREQ];
    logic [NREQ-1:0] eff;
    logic            found;
    logic [LGW-1:0]  win;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign din_arr[gi] = din[gi*W +: W];
    end

    // A requester whose ack is currently visible is masked so that one that
    // drops req on seeing ack cannot be loaded a second time.
    assign eff = req & ~ack_q;

    // Scan from last_grant+1 upward with wrap; last winner has lowest priority.
    always_comb begin
        int idx;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int off = 1; off <= NREQ; off++) begin
            idx = (int'(lg_q) + off) % NREQ;
            if (!found && eff[idx]) begin
                found = 1'b1;
                win   = LGW'(idx);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sample_d = sample_q;
        valid_d  = valid_q;
        ack_d    = '0;
        busy_d   = busy_q;
        lg_d     = lg_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    sample_d   = din_arr[win];
                    ack_d[win] = 1'b1;
                    lg_d       = win;
                    valid_d    = 1'b1;
                    if (HOLD > 0) begin
                        state_d = HOLDING;
                        cnt_d   = HOLD_M1;
                        busy_d  = 1'b1;
                    end
                end
            end
            HOLDING: begin
                if (cnt_q == 8'd0) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= 8'd0;
            sample_q <= '0;
            valid_q  <= 1'b0;
            ack_q    <= '0;
            busy_q   <= 1'b0;
            lg_q     <= LG_RST;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
            ack_q    <= ack_d;
            busy_q   <= busy_d;
            lg_q     <= lg_d;
        end
    end

    assign q          = sample_q;
    assign q_valid    = valid_q;
    assign ack        = ack_q;
    assign busy       = busy_q;
    assign last_grant = lg_q;

endmodule

// File: tb/tb_sample_load_arbiter.sv
// Bench for sample_load_arbiter: two instances (HOLD=0 and HOLD=3) driven by
// a per-cycle vector table, plus a bounded-wait sequence for request-in-hold.
module tb_sample_load_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // HOLD=0 instance
    logic        rst0 = 1'b1;
    logic [3:0]  req0 = 4'b0;
    logic [63:0] din0 = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
    logic [15:0] q0;
    logic        v0;
    logic [3:0]  ack0;
    logic        busy0;
    logic [1:0]  lg0;

    // HOLD=3 instance
    logic        rst3 = 1'b1;
    logic [3:0]  req3 = 4'b0;
    logic [63:0] din3 = {16'h4444, 16'h1234, 16'h2222, 16'h1111};
    logic [15:0] q3;
    logic        v3;
    logic [3:0]  ack3;
    logic        busy3;
    logic [1:0]  lg3;

    sample_load_arbiter #(.NREQ(4), .W(16), .HOLD(0)) dut0 (
        .clk(clk), .reset(rst0), .req(req0), .din(din0),
        .q(q0), .q_valid(v0), .ack(ack0), .busy(busy0), .last_grant(lg0)
    );

    sample_load_arbiter #(.NREQ(4), .W(16), .HOLD(3)) dut3 (
        .clk(clk), .reset(rst3), .req(req3), .din(din3),
        .q(q3), .q_valid(v3), .ack(ack3), .busy(busy3), .last_grant(lg3)
    );

    typedef struct {
        logic        sel;   // 0: HOLD=0 instance, 1: HOLD=3 instance
        logic        rst;
        logic [3:0]  req;
        logic [15:0] q;
        logic [3:0]  ack;
        logic        busy;
        logic        vld;
        logic [1:0]  lg;
    } vec_t;

    vec_t vt[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic sel, input logic rst, input logic [3:0] req,
                       input logic [15:0] q, input logic [3:0] ack, input logic busy,
                       input logic vld, input logic [1:0] lg);
        vec_t v;
        v.sel = sel; v.rst = rst; v.req = req; v.q = q;
        v.ack = ack; v.busy = busy; v.vld = vld; v.lg = lg;
        vt.push_back(v);
    endtask

    initial begin
        int cyc;
        logic got;

        // Each row: inputs sampled at an edge, outputs expected after it.
        // HOLD=0: reset with all requests, full contention, then self-repeat.
        add(0, 1, 4'b1111, 16'h0000, 4'b0000, 0, 0, 2'd3);
        add(0, 1, 4'b1111, 16'h0000, 4'b0000, 0, 0, 2'd3);
        add(0, 1, 4'b1111, 16'h0000, 4'b0000, 0, 0, 2'd3);
        add(0, 0, 4'b1111, 16'hA000, 4'b0001, 0, 1, 2'd0);
        add(0, 0, 4'b1111, 16'hA001, 4'b0010, 0, 1, 2'd1);
        add(0, 0, 4'b1111, 16'hA002, 4'b0100, 0, 1, 2'd2);
        add(0, 0, 4'b1111, 16'hA003, 4'b1000, 0, 1, 2'd3);
        add(0, 0, 4'b1111, 16'hA000, 4'b0001, 0, 1, 2'd0);
        add(0, 0, 4'b0010, 16'hA001, 4'b0010, 0, 1, 2'd1);
        add(0, 0, 4'b0010, 16'hA001, 4'b0000, 0, 1, 2'd1);
        add(0, 0, 4'b0010, 16'hA001, 4'b0010, 0, 1, 2'd1);
        add(0, 0, 4'b0010, 16'hA001, 4'b0000, 0, 1, 2'd1);
        add(0, 0, 4'b0010, 16'hA001, 4'b0010, 0, 1, 2'd1);
        // HOLD=3: reset, single load, request during hold, reset mid-hold.
        add(1, 1, 4'b1111, 16'h0000, 4'b0000, 0, 0, 2'd3);
        add(1, 0, 4'b0100, 16'h1234, 4'b0100, 1, 1, 2'd2);
        add(1, 0, 4'b0000, 16'h1234, 4'b0000, 1, 1, 2'd2);
        add(1, 0, 4'b0000, 16'h1234, 4'b0000, 1, 1, 2'd2);
        add(1, 0, 4'b0000, 16'h1234, 4'b0000, 0, 1, 2'd2);
        add(1, 0, 4'b0001, 16'h1111, 4'b0001, 1, 1, 2'd0);
        add(1, 0, 4'b0010, 16'h1111, 4'b0000, 1, 1, 2'd0);
        add(1, 0, 4'b0010, 16'h1111, 4'b0000, 1, 1, 2'd0);
        add(1, 0, 4'b0010, 16'h1111, 4'b0000, 0, 1, 2'd0);
        add(1, 0, 4'b0010, 16'h2222, 4'b0010, 1, 1, 2'd1);
        add(1, 0, 4'b1000, 16'h2222, 4'b0000, 1, 1, 2'd1);
        add(1, 1, 4'b1000, 16'h0000, 4'b0000, 0, 0, 2'd3);
        add(1, 0, 4'b1000, 16'h4444, 4'b1000, 1, 1, 2'd3);

        @(negedge clk);
        foreach (vt[i]) begin
            if (vt[i].sel == 1'b0) begin
                rst0 = vt[i].rst; req0 = vt[i].req;
                rst3 = 1'b1;      req3 = 4'b0;
            end else begin
                rst3 = vt[i].rst; req3 = vt[i].req;
                rst0 = 1'b0;      req0 = 4'b0;
            end
            @(posedge clk);
            #1;
            if (vt[i].sel == 1'b0) begin
                chk($sformatf("row%0d_q", i),    32'(q0),    32'(vt[i].q));
                chk($sformatf("row%0d_ack", i),  32'(ack0),  32'(vt[i].ack));
                chk($sformatf("row%0d_busy", i), 32'(busy0), 32'(vt[i].busy));
                chk($sformatf("row%0d_vld", i),  32'(v0),    32'(vt[i].vld));
                chk($sformatf("row%0d_lg", i),   32'(lg0),   32'(vt[i].lg));
            end else begin
                chk($sformatf("row%0d_q", i),    32'(q3),    32'(vt[i].q));
                chk($sformatf("row%0d_ack", i),  32'(ack3),  32'(vt[i].ack));
                chk($sformatf("row%0d_busy", i), 32'(busy3), 32'(vt[i].busy));
                chk($sformatf("row%0d_vld", i),  32'(v3),    32'(vt[i].vld));
                chk($sformatf("row%0d_lg", i),   32'(lg3),   32'(vt[i].lg));
            end
            $display("vec %0d sel=%0d rst=%0d req=%b -> q=%h ack=%b busy=%0d", i,
                     vt[i].sel, vt[i].rst, vt[i].req,
                     vt[i].sel ? q3 : q0, vt[i].sel ? ack3 : ack0,
                     vt[i].sel ? busy3 : busy0);
            @(negedge clk);
        end

        // HOLD=3 instance was just loaded with requester 3; raise req[1] in
        // the first hold cycle and wait (bounded) for its ack. Load edge k ->
        // grant edge k+4, i.e. the 4th edge after raising req here.
        req3 = 4'b0010;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 12) begin
            @(posedge clk);
            #1;
            cyc++;
            if (ack3 != 4'b0000) got = 1'b1;
        end
        chk("hold_wait_seen", 32'(got), 32'd1);
        chk("hold_wait_cycles", 32'(cyc), 32'd4);
        chk("hold_wait_ack", 32'(ack3), 32'b0010);
        chk("hold_wait_q", 32'(q3), 32'h2222);
        $display("seq hold_wait: ack after %0d edges q=%h lg=%0d", cyc, q3, lg3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
